// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: zero-clears x1..x(NREGS-1) after reset, then arbitrates
// ALU and LSU write-back requests. Define WB_RR_EN for round-robin arbitration on contention.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned NREGS          = 32,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [$clog2(NREGS)-1:0] alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  output logic                     alu_ready,
  input  logic                     lsu_valid,
  input  logic [$clog2(NREGS)-1:0] lsu_rd,
  input  logic [XLEN-1:0]          lsu_data,
  output logic                     lsu_ready,
  output logic                     wrt_en,
  output logic [$clog2(NREGS)-1:0] oprd,
  output logic [XLEN-1:0]          wrt_data,
  output logic                     init_done
);

  localparam int unsigned IDXW = $clog2(NREGS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREGS - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_t          state_q, state_d;
  logic [IDXW-1:0] clr_cnt_q, clr_cnt_d;
  logic            wrt_en_d;
  logic [IDXW-1:0] oprd_d;
  logic [XLEN-1:0] wrt_data_d;
  logic            init_done_d;
  logic [IDXW-1:0] clr_tgt;
  logic            lsu_pri;

`ifdef WB_RR_EN
  // Last granted requester: 0 = ALU, 1 = LSU; the other side wins the next conflict.
  logic last_lsu_q, last_lsu_d;
  assign lsu_pri = ~last_lsu_q;
`else
  assign lsu_pri = 1'b1;
`endif

  // clr_cnt counts completed clear writes, so the register being cleared is one ahead.
  assign clr_tgt = clr_cnt_q + IDXW'(1);

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    wrt_en_d    = 1'b0;
    oprd_d      = oprd;
    wrt_data_d  = wrt_data;
    init_done_d = init_done;
    alu_ready   = 1'b0;
    lsu_ready   = 1'b0;
`ifdef WB_RR_EN
    last_lsu_d  = last_lsu_q;
`endif
    case (state_q)
      ST_CLEAR: begin
        wrt_en_d   = 1'b1;
        oprd_d     = clr_tgt;
        wrt_data_d = '0;
        clr_cnt_d  = clr_tgt;
        if (clr_tgt == LAST_IDX) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        init_done_d = 1'b1;
        lsu_ready   = lsu_valid & (~alu_valid | lsu_pri);
        alu_ready   = alu_valid & ~lsu_ready;
        // Writes to x0 are accepted but dropped; index/data then hold their last value.
        if (lsu_ready) begin
          wrt_en_d = (lsu_rd != '0);
          if (lsu_rd != '0) begin
            oprd_d     = lsu_rd;
            wrt_data_d = lsu_data;
          end
        end else if (alu_ready) begin
          wrt_en_d = (alu_rd != '0);
          if (alu_rd != '0) begin
            oprd_d     = alu_rd;
            wrt_data_d = alu_data;
          end
        end
`ifdef WB_RR_EN
        if (lsu_ready) begin
          last_lsu_d = 1'b1;
        end else if (alu_ready) begin
          last_lsu_d = 1'b0;
        end
`endif
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RST_STATE;
      clr_cnt_q  <= '0;
      wrt_en     <= 1'b0;
      oprd       <= '0;
      wrt_data   <= '0;
      init_done  <= 1'b0;
`ifdef WB_RR_EN
      last_lsu_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wrt_en     <= wrt_en_d;
      oprd       <= oprd_d;
      wrt_data   <= wrt_data_d;
      init_done  <= init_done_d;
`ifdef WB_RR_EN
      last_lsu_q <= last_lsu_d;
`endif
    end
  end

endmodule
